// File: rtl/bsg_mem_1rw_sync_mask_write_bit_banked_init_if.sv
// rtl/bsg_mem_1rw_sync_mask_write_bit_banked_init_if.sv - request/response bundle for the banked masked-write 1RW memory
interface bsg_mem_1rw_sync_mask_write_bit_banked_init_if #(
  parameter int width_p = 64,
  parameter int els_p   = 256
);
  localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;

  logic                     v_i;
  logic                     ready_o;
  logic                     w_i;
  logic [addr_width_lp-1:0] addr_i;
  logic [width_p-1:0]       data_i;
  logic [width_p-1:0]       w_mask_i;
  logic [width_p-1:0]       data_o;
  logic                     v_o;
  logic                     init_done_o;

  modport master (
    output v_i, w_i, addr_i, data_i, w_mask_i,
    input  ready_o, data_o, v_o, init_done_o
  );

  modport slave (
    input  v_i, w_i, addr_i, data_i, w_mask_i,
    output ready_o, data_o, v_o, init_done_o
  );
endinterface

// File: rtl/bsg_mem_1rw_sync_mask_write_bit_banked_init.sv
// rtl/bsg_mem_1rw_sync_mask_write_bit_banked_init.sv - depth-banked bit-masked 1RW memory with post-reset zero fill
module bsg_mem_1rw_sync_mask_write_bit_banked_init #(
  parameter int width_p           = 64,
  parameter int els_p             = 256,
  parameter int num_banks_p       = 2,
  parameter int latch_last_read_p = 1,
  parameter int init_zero_p       = 1
) (
  input  logic clk_i,
  input  logic reset_n_i,
  bsg_mem_1rw_sync_mask_write_bit_banked_init_if.slave bus
);

  localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int bank_bits_lp  = (num_banks_p > 1) ? $clog2(num_banks_p) : 0;
  localparam int bank_width_lp = (bank_bits_lp > 0) ? bank_bits_lp : 1;
  localparam int rows_lp       = els_p / num_banks_p;
  localparam int row_width_lp  = (rows_lp > 1) ? $clog2(rows_lp) : 1;

  localparam logic [0:0] eINIT  = 1'b0;
  localparam logic [0:0] eREADY = 1'b1;

  localparam logic [row_width_lp-1:0] last_row_lp = row_width_lp'(rows_lp - 1);

  logic [0:0]              state_r;
  logic [row_width_lp-1:0] row_r;
  logic                    init_active;
  logic                    ready;
  logic                    accept;
  logic                    addr_ok;
  logic                    req_go;
  logic                    rd_go;
  logic [bank_width_lp-1:0] req_bank;
  logic [row_width_lp-1:0]  req_row;

  logic                     bank_w;
  logic [row_width_lp-1:0]  bank_row;
  logic [width_p-1:0]       bank_data;
  logic [width_p-1:0]       bank_mask;
  logic [width_p-1:0]       bank_q [num_banks_p];
  logic [width_p-1:0]       bank_out;

  logic                     rv_r;
  logic [bank_width_lp-1:0] sel_r;

  assign init_active = (state_r == eINIT);
  assign ready       = (state_r == eREADY);
  assign accept      = bus.v_i & ready;
  // Out-of-range requests are dropped so they can never alias onto a real row.
  assign req_go      = accept & addr_ok;
  assign rd_go       = req_go & ~bus.w_i;

  assign bus.ready_o     = ready;
  assign bus.init_done_o = ready;
  assign bus.v_o         = rv_r;

  // Low address bits pick the bank so consecutive addresses land in different banks.
  if (bank_bits_lp > 0) begin : g_bank_sel
    assign req_bank = bus.addr_i[bank_bits_lp-1:0];
  end else begin : g_single_bank
    assign req_bank = '0;
  end

  assign req_row = row_width_lp'(bus.addr_i >> bank_bits_lp);

  // When els_p fills the address space every address is legal.
  if (els_p == (1 << addr_width_lp)) begin : g_full_range
    assign addr_ok = 1'b1;
  end else begin : g_partial_range
    assign addr_ok = (bus.addr_i < addr_width_lp'(els_p));
  end

  // During the sweep all banks share the same row and write zero with a full mask.
  assign bank_w    = init_active | bus.w_i;
  assign bank_row  = init_active ? row_r : req_row;
  assign bank_data = init_active ? '0 : bus.data_i;
  assign bank_mask = init_active ? '1 : bus.w_mask_i;

  for (genvar b = 0; b < num_banks_p; b++) begin : g_bank
    logic [width_p-1:0] mem_r [rows_lp];
    logic [width_p-1:0] q_r;
    logic               en;

    assign en = init_active | (req_go & (req_bank == bank_width_lp'(b)));

    // Synchronous 1RW bank: masked read-modify-write on write, registered output on read.
    always_ff @(posedge clk_i) begin
      if (en) begin
        if (bank_w) begin
          mem_r[bank_row] <= (mem_r[bank_row] & ~bank_mask) | (bank_data & bank_mask);
        end else begin
          q_r <= mem_r[bank_row];
        end
      end
    end

    assign bank_q[b] = q_r;
  end

  // Zero-fill sweep: one row per cycle, then park in eREADY until the next reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= (init_zero_p != 0) ? eINIT : eREADY;
      row_r   <= '0;
    end else if (state_r == eINIT) begin
      if (row_r == last_row_lp) begin
        state_r <= eREADY;
      end else begin
        row_r <= row_r + row_width_lp'(1);
      end
    end
  end

  // Read-valid pulse and the bank index needed to steer the output one cycle later.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rv_r  <= 1'b0;
      sel_r <= '0;
    end else begin
      rv_r <= rd_go;
      if (rd_go) begin
        sel_r <= req_bank;
      end
    end
  end

  assign bank_out = bank_q[sel_r];

  if (latch_last_read_p != 0) begin : g_hold
    logic [width_p-1:0] hold_r;

    // Remember the last read so data_o is stable between reads, independent of later writes.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        hold_r <= '0;
      end else if (rv_r) begin
        hold_r <= bank_out;
      end
    end

    assign bus.data_o = rv_r ? bank_out : hold_r;
  end else begin : g_no_hold
    assign bus.data_o = rv_r ? bank_out : '0;
  end

`ifndef SYNTHESIS
  // Flag requests the hardware silently drops.
  always_ff @(posedge clk_i) begin
    if (reset_n_i && accept && !addr_ok) begin
      $error("bsg_mem_1rw_sync_mask_write_bit_banked_init: addr_i %0d out of range", bus.addr_i);
    end
  end
`endif

endmodule
